config_frame_loader: RTL

- Upstream stage of every tile's configuration memory.
- Receives a 32-bit configuration word stream and detects the sync word.
- Parses each frame header, then assembles one full-height frame of FrameData across all rows.
- Pulses exactly one FrameStrobe bit, selected by column and frame index, to latch the assembled frame into that column's tiles.

---
 rtl/config_frame_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/config_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_loader
// Description : Sync-word detection, frame header parsing and full-height
//               frame assembly with a one-hot per-column frame strobe.
// Revision    : 1.0
// ============================================================================
module config_frame_loader #(
    parameter int          NUMBER_OF_ROWS     = 16,
    parameter int          NUMBER_OF_COLS     = 8,
    parameter int          FRAME_BITS_PER_ROW = 32,
    parameter int          MAX_FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1
) (
    input  logic                                       CLK,
    input  logic                                       resetn,
    input  logic [31:0]                                WriteData,
    input  logic                                       WriteStrobe,
    output logic [FRAME_BITS_PER_ROW*NUMBER_OF_ROWS-1:0] FrameData,
    output logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0] FrameStrobe,
    output logic                                       ConfigBusy,
    output logic                                       ConfigError
);

    localparam int STROBE_W = MAX_FRAMES_PER_COL * NUMBER_OF_COLS;
    localparam int ROW_W    = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
    localparam int IDX_W    = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUMBER_OF_ROWS - 1);
    localparam logic [7:0]       COL_LIMIT   = 8'(NUMBER_OF_COLS);
    localparam logic [7:0]       FRAME_LIMIT = 8'(MAX_FRAMES_PER_COL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    state_e                                     state_q, state_d;
    logic [ROW_W-1:0]                           row_q, row_d;
    logic [7:0]                                 col_q, col_d;
    logic [7:0]                                 frame_q, frame_d;
    logic                                       discard_q, discard_d;
    logic                                       config_error_q, config_error_d;
    logic [FRAME_BITS_PER_ROW*NUMBER_OF_ROWS-1:0] frame_data_q, frame_data_d;
    logic [STROBE_W-1:0]                        frame_strobe_q, frame_strobe_d;
    logic [IDX_W-1:0]                           strobe_idx;

    assign strobe_idx = IDX_W'(col_q) * IDX_W'(MAX_FRAMES_PER_COL) + IDX_W'(frame_q);

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        frame_d        = frame_q;
        discard_d      = discard_q;
        config_error_d = config_error_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = '0;

        if (WriteStrobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (WriteData == SYNC_WORD) begin
                        state_d        = ST_HEADER;
                        config_error_d = 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (WriteData[31]) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d   = WriteData[15:8];
                        frame_d = WriteData[7:0];
                        row_d   = '0;
                        state_d = ST_DATA;
                        // A bad header still consumes its data words to keep the stream aligned
                        discard_d = (WriteData[15:8] >= COL_LIMIT) ||
                                    (WriteData[7:0]  >= FRAME_LIMIT);
                        if (discard_d) begin
                            config_error_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    for (int r = 0; r < NUMBER_OF_ROWS; r++) begin
                        if (row_q == ROW_W'(r)) begin
                            frame_data_d[r*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = WriteData;
                        end
                    end
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = ST_HEADER;
                        if (!discard_q) begin
                            for (int i = 0; i < STROBE_W; i++) begin
                                if (strobe_idx == IDX_W'(i)) begin
                                    frame_strobe_d[i] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            frame_q        <= '0;
            discard_q      <= 1'b0;
            config_error_q <= 1'b0;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            frame_q        <= frame_d;
            discard_q      <= discard_d;
            config_error_q <= config_error_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign ConfigBusy  = (state_q != ST_IDLE);
    assign ConfigError = config_error_q;

endmodule
`default_nettype wire
